// File: rtl/maze_pkg.sv
// Shared definitions for the memory-maze move engine: state encoding, directions, difficulties.
package maze_pkg;

  localparam int unsigned NUM_STATES = 7;
  localparam int unsigned STATE_W    = 3;

  // Index form of each state; also the bit position in the one-hot state vector.
  typedef enum logic [STATE_W-1:0] {
    ST_MENU  = 3'd0,
    ST_SHOW  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_FETCH = 3'd3,
    ST_CHECK = 3'd4,
    ST_LOST  = 3'd5,
    ST_WON   = 3'd6
  } state_idx_e;

  typedef logic [NUM_STATES-1:0] state_oh_t;

  localparam state_oh_t OH_MENU  = 7'b000_0001;
  localparam state_oh_t OH_SHOW  = 7'b000_0010;
  localparam state_oh_t OH_PLAY  = 7'b000_0100;
  localparam state_oh_t OH_FETCH = 7'b000_1000;
  localparam state_oh_t OH_CHECK = 7'b001_0000;
  localparam state_oh_t OH_LOST  = 7'b010_0000;
  localparam state_oh_t OH_WON   = 7'b100_0000;

  // Bit positions within the move pulse vector.
  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    DIFF_EASY  = 2'd0,
    DIFF_MED   = 2'd1,
    DIFF_HARD  = 2'd2,
    DIFF_HARD2 = 2'd3
  } diff_e;

  // Collapse a one-hot state vector to its index form for the state output.
  function automatic state_idx_e oh_to_idx(input state_oh_t oh);
    state_idx_e idx;
    idx = ST_MENU;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      if (oh[i]) idx = state_idx_e'(3'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/maze_preview_timer.sv
// Loadable down-counter that times the map preview; done is high while the count is zero.
module maze_preview_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/maze_move_engine.sv
// Game FSM, map preview, player position and ROM-backed wall/goal checks for the memory maze.
module maze_move_engine
  import maze_pkg::*;
#(
  parameter int unsigned GRID_W    = 30,
  parameter int unsigned GRID_H    = 21,
  parameter int unsigned SHOW_EASY = 150_000_000,
  parameter int unsigned SHOW_MED  = 100_000_000,
  parameter int unsigned SHOW_HARD = 50_000_000,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned START_X   = 0,
  parameter int unsigned START_Y   = 0,
  parameter int unsigned GOAL_X    = GRID_W - 1,
  parameter int unsigned GOAL_Y    = GRID_H - 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  difficulty,
  input  logic [3:0]                  move,
  output logic [$clog2(GRID_H)-1:0]   map_addr,
  input  logic [GRID_W-1:0]           map_data,
  output logic [$clog2(GRID_W)-1:0]   player_x,
  output logic [$clog2(GRID_H)-1:0]   player_y,
  output logic [2:0]                  state,
  output logic                        map_visible,
  output logic [$clog2(LIVES+1)-1:0]  lives,
  output logic                        lost,
  output logic                        won
);

  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned LW = $clog2(LIVES + 1);
  localparam int unsigned SHOW_MAX =
    (SHOW_EASY > SHOW_MED) ? ((SHOW_EASY > SHOW_HARD) ? SHOW_EASY : SHOW_HARD)
                           : ((SHOW_MED  > SHOW_HARD) ? SHOW_MED  : SHOW_HARD);
  localparam int unsigned CNT_W = (SHOW_MAX > 1) ? $clog2(SHOW_MAX) : 1;

  state_oh_t   state_q, state_d;
  state_idx_e  state_idx_q;
  logic [XW-1:0] px_q, px_d, tx_q, tx_d;
  logic [YW-1:0] py_q, py_d, ty_q, ty_d;
  logic [YW-1:0] addr_q, addr_d;
  logic [LW-1:0] lives_q, lives_d;
  logic          lost_q, lost_d, won_q, won_d, vis_q, vis_d;

  logic             tmr_load_c, tmr_done_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             mv_ok_c, wall_c, goal_c;
  logic [XW-1:0]    mv_x_c;
  logic [YW-1:0]    mv_y_c;

  maze_preview_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .en_i       (state_q[ST_SHOW]),
    .done_c     (tmr_done_c)
  );

  // Pick one direction by priority, then drop it if the target leaves the grid.
  always_comb begin
    mv_ok_c = 1'b0;
    mv_x_c  = px_q;
    mv_y_c  = py_q;
    if (move[DIR_UP]) begin
      if (py_q != '0) begin
        mv_ok_c = 1'b1;
        mv_y_c  = py_q - YW'(1);
      end
    end else if (move[DIR_DOWN]) begin
      if (py_q != YW'(GRID_H - 1)) begin
        mv_ok_c = 1'b1;
        mv_y_c  = py_q + YW'(1);
      end
    end else if (move[DIR_LEFT]) begin
      if (px_q != '0) begin
        mv_ok_c = 1'b1;
        mv_x_c  = px_q - XW'(1);
      end
    end else if (move[DIR_RIGHT]) begin
      if (px_q != XW'(GRID_W - 1)) begin
        mv_ok_c = 1'b1;
        mv_x_c  = px_q + XW'(1);
      end
    end
  end

  assign wall_c = map_data[tx_q];
  assign goal_c = (tx_q == XW'(GOAL_X)) && (ty_q == YW'(GOAL_Y));

  // Preview length chosen by the difficulty presented alongside start.
  always_comb begin
    unique case (diff_e'(difficulty))
      DIFF_EASY: tmr_val_c = CNT_W'(SHOW_EASY - 1);
      DIFF_MED:  tmr_val_c = CNT_W'(SHOW_MED - 1);
      default:   tmr_val_c = CNT_W'(SHOW_HARD - 1);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OH_MENU;
      state_idx_q <= ST_MENU;
    end else begin
      state_q     <= state_d;
      state_idx_q <= oh_to_idx(state_d);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (state_q[ST_MENU]) begin
      if (start) state_d = OH_SHOW;
    end else if (state_q[ST_SHOW]) begin
      if (tmr_done_c) state_d = OH_PLAY;
    end else if (state_q[ST_PLAY]) begin
      if (mv_ok_c) state_d = OH_FETCH;
    end else if (state_q[ST_FETCH]) begin
      state_d = OH_CHECK;
    end else if (state_q[ST_CHECK]) begin
      if (wall_c) state_d = (lives_q == LW'(1)) ? OH_LOST : OH_PLAY;
      else        state_d = goal_c ? OH_WON : OH_PLAY;
    end else if (state_q[ST_LOST] || state_q[ST_WON]) begin
      if (start) state_d = OH_MENU;
    end else begin
      state_d = OH_MENU;
    end
  end

  // Output and datapath next values.
  always_comb begin
    px_d       = px_q;
    py_d       = py_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    lives_d    = lives_q;
    lost_d     = lost_q;
    won_d      = won_q;
    addr_d     = '0;
    tmr_load_c = 1'b0;
    vis_d      = state_d[ST_SHOW] || state_d[ST_LOST] || state_d[ST_WON];
    if (state_q[ST_MENU] && start) begin
      tmr_load_c = 1'b1;
      lives_d    = LW'(LIVES);
      px_d       = XW'(START_X);
      py_d       = YW'(START_Y);
    end else if (state_q[ST_PLAY] && mv_ok_c) begin
      tx_d   = mv_x_c;
      ty_d   = mv_y_c;
      addr_d = mv_y_c;
    end else if (state_q[ST_FETCH]) begin
      addr_d = ty_q;
    end else if (state_q[ST_CHECK]) begin
      if (wall_c) begin
        lives_d = lives_q - LW'(1);
        vis_d   = 1'b1;
        if (lives_q == LW'(1)) lost_d = 1'b1;
      end else begin
        px_d = tx_q;
        py_d = ty_q;
        if (goal_c) won_d = 1'b1;
      end
    end else if ((state_q[ST_LOST] || state_q[ST_WON]) && start) begin
      lost_d = 1'b0;
      won_d  = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_q    <= XW'(START_X);
      py_q    <= YW'(START_Y);
      tx_q    <= '0;
      ty_q    <= '0;
      addr_q  <= '0;
      lives_q <= LW'(LIVES);
      lost_q  <= 1'b0;
      won_q   <= 1'b0;
      vis_q   <= 1'b0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      addr_q  <= addr_d;
      lives_q <= lives_d;
      lost_q  <= lost_d;
      won_q   <= won_d;
      vis_q   <= vis_d;
    end
  end

  assign map_addr    = addr_q;
  assign player_x    = px_q;
  assign player_y    = py_q;
  assign state       = state_idx_q;
  assign map_visible = vis_q;
  assign lives       = lives_q;
  assign lost        = lost_q;
  assign won         = won_q;

endmodule

// File: tb/tb_maze_move_engine.sv
// Directed bench for maze_move_engine on a 4x4 grid with one wall at (1,0) and goal (3,3).
module tb_maze_move_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] difficulty;
  logic [3:0] move;
  logic [1:0] map_addr;
  logic [3:0] map_data;
  logic [1:0] player_x;
  logic [1:0] player_y;
  logic [2:0] state;
  logic       map_visible;
  logic [1:0] lives;
  logic       lost;
  logic       won;

  int checks   = 0;
  int failures = 0;
  int vis_cnt;

  maze_move_engine #(
    .GRID_W(4), .GRID_H(4),
    .SHOW_EASY(10), .SHOW_MED(6), .SHOW_HARD(3),
    .LIVES(2),
    .START_X(0), .START_Y(0),
    .GOAL_X(3), .GOAL_Y(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .difficulty  (difficulty),
    .move        (move),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .player_x    (player_x),
    .player_y    (player_y),
    .state       (state),
    .map_visible (map_visible),
    .lives       (lives),
    .lost        (lost),
    .won         (won)
  );

  always #5 clk = ~clk;

  // Synchronous map ROM: only row 0 has a wall, at column 1.
  always_ff @(posedge clk) begin
    map_data <= (map_addr == 2'd0) ? 4'b0010 : 4'b0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse a move for one cycle and advance to the cycle where the position is updated.
  task automatic do_move(input logic [3:0] m);
    move = m;
    tick();
    move = 4'b0000;
    tick();
    tick();
  endtask

  // Pulse start from MENU and count preview cycles, bounded.
  task automatic start_game(input logic [1:0] d, output int n);
    difficulty = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (map_visible && n < 50) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    difficulty = 2'd0;
    move = 4'b0000;
    tick();
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_px", 32'(player_x), 0);
    check("rst_py", 32'(player_y), 0);
    check("rst_lives", 32'(lives), 2);
    check("rst_flags", 32'({lost, won, map_visible}), 0);
    check("rst_addr", 32'(map_addr), 0);
    reset = 1'b0;
    tick();

    // Preview for difficulty 1 is 6 cycles.
    start_game(2'd1, vis_cnt);
    check("preview_med_len", 32'(vis_cnt), 6);
    check("preview_med_play", 32'(state), 2);

    // Up at the top edge is dropped.
    move = 4'b0001;
    tick();
    move = 4'b0000;
    check("bound_up_state", 32'(state), 2);
    tick();
    tick();
    check("bound_up_pos", 32'({player_x, player_y}), 0);
    check("bound_up_lives", 32'(lives), 2);

    // Right into the wall at (1,0).
    move = 4'b1000;
    tick();
    move = 4'b0000;
    check("hit_fetch_state", 32'(state), 3);
    check("hit_fetch_addr", 32'(map_addr), 0);
    tick();
    check("hit_check_state", 32'(state), 4);
    tick();
    check("hit_lives", 32'(lives), 1);
    check("hit_pos", 32'({player_x, player_y}), 0);
    check("hit_flash", 32'(map_visible), 1);
    check("hit_back_play", 32'(state), 2);
    tick();
    check("hit_flash_end", 32'(map_visible), 0);

    // Second hit loses the game.
    do_move(4'b1000);
    check("loss_lives", 32'(lives), 0);
    check("loss_flag", 32'(lost), 1);
    check("loss_state", 32'(state), 5);
    check("loss_vis", 32'(map_visible), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("loss_menu_state", 32'(state), 0);
    check("loss_menu_flag", 32'(lost), 0);

    // Hard preview, then walk to the goal.
    start_game(2'd2, vis_cnt);
    check("preview_hard_len", 32'(vis_cnt), 3);
    check("game2_lives", 32'(lives), 2);
    do_move(4'b0010);
    check("down_py", 32'(player_y), 1);

    // A move during FETCH is dropped, not queued.
    move = 4'b0010;
    tick();
    move = 4'b1000;
    tick();
    move = 4'b0000;
    tick();
    check("drop_py", 32'(player_y), 2);
    tick();
    check("drop_state", 32'(state), 2);
    check("drop_px", 32'(player_x), 0);

    do_move(4'b1001);
    check("prio_up_pos", 32'({player_x, player_y}), 32'({2'd0, 2'd1}));
    do_move(4'b0010);
    do_move(4'b0010);
    do_move(4'b1000);
    do_move(4'b1000);
    check("walk_pos", 32'({player_x, player_y}), 32'({2'd2, 2'd3}));
    do_move(4'b1001);
    check("prio_up2_pos", 32'({player_x, player_y}), 32'({2'd2, 2'd2}));
    do_move(4'b0110);
    check("prio_down_pos", 32'({player_x, player_y}), 32'({2'd2, 2'd3}));
    do_move(4'b1000);
    check("win_pos", 32'({player_x, player_y}), 32'({2'd3, 2'd3}));
    check("win_flag", 32'(won), 1);
    check("win_state", 32'(state), 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("win_menu_flag", 32'(won), 0);

    // Asynchronous reset while in CHECK.
    start_game(2'd3, vis_cnt);
    check("preview_hard2_len", 32'(vis_cnt), 3);
    do_move(4'b1000);
    do_move(4'b0010);
    check("pre_rst_lives", 32'(lives), 1);
    move = 4'b0010;
    tick();
    move = 4'b0000;
    tick();
    check("pre_rst_check", 32'(state), 4);
    reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_pos", 32'({player_x, player_y}), 0);
    check("arst_lives", 32'(lives), 2);
    check("arst_addr", 32'(map_addr), 0);
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
